// File: rtl/scr1_tapc_fsm_ctrl.sv
// JTAG TAP controller core: 16-state TAP FSM, instruction register, DR select and TDO mux.
// Optional internal bypass register enabled by defining SCR1_TAPC_BYPASS_EN.
module scr1_tapc_fsm_ctrl #(
    parameter int                       SCR1_IR_WIDTH   = 5,
    parameter logic [SCR1_IR_WIDTH-1:0] SCR1_IR_IDCODE  = 'h01,
    parameter logic [SCR1_IR_WIDTH-1:0] SCR1_IR_BYPASS  = 'h1F,
    parameter int                       SCR1_DR_NUM     = 4,
    parameter logic [SCR1_IR_WIDTH-1:0] SCR1_DR_BASE_IR = 'h01
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tms,
    input  logic                     tdi,
    input  logic [SCR1_DR_NUM-1:0]   dr_tdo,
    output logic                     rst_n_sync,
    output logic [SCR1_DR_NUM-1:0]   fsm_dr_select,
    output logic                     fsm_dr_capture,
    output logic                     fsm_dr_shift,
    output logic                     fsm_dr_update,
    output logic [SCR1_IR_WIDTH-1:0] ir_value,
    output logic                     tdo,
    output logic                     tdo_en
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHF_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHF_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    tap_state_e               state;
    logic [SCR1_IR_WIDTH-1:0] ir;
    logic [SCR1_IR_WIDTH-1:0] ir_shift;
    logic                     dr_none;
    logic                     dr_tdo_sel;
    logic                     bypass_bit;
    logic                     tdo_next;

    // TAP state machine plus the IR chain it owns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TLR;
            ir       <= SCR1_IR_IDCODE;
            ir_shift <= '0;
        end else begin
            case (state)
                TLR:    state <= tms ? TLR    : RTI;
                RTI:    state <= tms ? SEL_DR : RTI;
                SEL_DR: state <= tms ? SEL_IR : CAP_DR;
                CAP_DR: state <= tms ? EX1_DR : SHF_DR;
                SHF_DR: state <= tms ? EX1_DR : SHF_DR;
                EX1_DR: state <= tms ? UPD_DR : PAU_DR;
                PAU_DR: state <= tms ? EX2_DR : PAU_DR;
                EX2_DR: state <= tms ? UPD_DR : SHF_DR;
                UPD_DR: state <= tms ? SEL_DR : RTI;
                SEL_IR: state <= tms ? TLR    : CAP_IR;
                CAP_IR: state <= tms ? EX1_IR : SHF_IR;
                SHF_IR: state <= tms ? EX1_IR : SHF_IR;
                EX1_IR: state <= tms ? UPD_IR : PAU_IR;
                PAU_IR: state <= tms ? EX2_IR : PAU_IR;
                EX2_IR: state <= tms ? UPD_IR : SHF_IR;
                UPD_IR: state <= tms ? SEL_DR : RTI;
                default: state <= TLR;
            endcase

            case (state)
                TLR:    ir       <= SCR1_IR_IDCODE;
                CAP_IR: ir_shift <= {{(SCR1_IR_WIDTH-2){1'b0}}, 2'b01};
                SHF_IR: ir_shift <= {tdi, ir_shift[SCR1_IR_WIDTH-1:1]};
                UPD_IR: ir       <= ir_shift;
                default: ;
            endcase
        end
    end

    assign ir_value       = ir;
    assign rst_n_sync     = (state != TLR);
    assign fsm_dr_capture = (state == CAP_DR);
    assign fsm_dr_shift   = (state == SHF_DR);
    assign fsm_dr_update  = (state == UPD_DR);

    // A DR mapped onto the BYPASS code is never selected
    for (genvar i = 0; i < SCR1_DR_NUM; i++) begin : g_dr_sel
        localparam logic [SCR1_IR_WIDTH-1:0] DR_CODE = SCR1_IR_WIDTH'(SCR1_DR_BASE_IR + i);
        assign fsm_dr_select[i] = (ir == DR_CODE) && (ir != SCR1_IR_BYPASS);
    end

    assign dr_none    = ~|fsm_dr_select;
    assign dr_tdo_sel = |(dr_tdo & fsm_dr_select);

`ifdef SCR1_TAPC_BYPASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bypass_bit <= 1'b0;
        else if (state == CAP_DR)
            bypass_bit <= 1'b0;
        else if (state == SHF_DR && dr_none)
            bypass_bit <= tdi;
    end
`else
    assign bypass_bit = 1'b0;
`endif

    always_comb begin
        tdo_next = 1'b0;
        case (state)
            SHF_IR:  tdo_next = ir_shift[0];
            SHF_DR:  tdo_next = dr_none ? bypass_bit : dr_tdo_sel;
            default: tdo_next = 1'b0;
        endcase
    end

    // TDO launches on the falling edge so it is stable for the next rising edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= (state == SHF_DR) || (state == SHF_IR);
            tdo    <= tdo_next;
        end
    end

endmodule

// File: tb/tb_scr1_tapc_fsm_ctrl.sv
// Directed bench for scr1_tapc_fsm_ctrl: expected TDO bits queued by the driver, checked by a monitor.
module tb_scr1_tapc_fsm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tms;
    logic       tdi;
    logic [3:0] dr_tdo;
    logic       rst_n_sync;
    logic [3:0] fsm_dr_select;
    logic       fsm_dr_capture;
    logic       fsm_dr_shift;
    logic       fsm_dr_update;
    logic [4:0] ir_value;
    logic       tdo;
    logic       tdo_en;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];
    bit cnt_en = 1'b0;
    int cap_cnt = 0, shf_cnt = 0, upd_cnt = 0;

    scr1_tapc_fsm_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tms(tms), .tdi(tdi), .dr_tdo(dr_tdo),
        .rst_n_sync(rst_n_sync), .fsm_dr_select(fsm_dr_select),
        .fsm_dr_capture(fsm_dr_capture), .fsm_dr_shift(fsm_dr_shift),
        .fsm_dr_update(fsm_dr_update), .ir_value(ir_value),
        .tdo(tdo), .tdo_en(tdo_en)
    );

    always #5 clk = ~clk;

    // Monitor: tdo_en marks a valid TDO bit, stable at the rising edge
    always @(posedge clk) begin
        if (rst_n && tdo_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tdo_unexpected: tdo_en=1 tdo=%0b, no bit expected", tdo);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (tdo !== e) begin
                    n_err++;
                    $display("FAIL tdo_bit: got %0b want %0b at %0t", tdo, e, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cnt_en) begin
            cap_cnt += int'(fsm_dr_capture);
            shf_cnt += int'(fsm_dr_shift);
            upd_cnt += int'(fsm_dr_update);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic tms_v);
        tms = tms_v;
        @(posedge clk);
        #1;
    endtask

    // From RTI, load an IR code; optional 3-clock Pause-IR after the second bit
    task automatic ir_scan(input logic [4:0] code, input bit pause);
        step(1); step(1); step(0); step(0);
        for (int k = 0; k < 5; k++) begin
            tdi = code[k];
            exp_q.push_back(k == 0);
            step(k == 4 || (pause && k == 1));
            if (pause && k == 1) begin
                step(0); step(0);
                @(negedge clk); #1;
                check("tdo_en_pause", 32'(tdo_en), 0);
                step(0); step(1); step(0);
            end
        end
        tdi = 1'b0;
        step(1); step(0);
    endtask

    initial begin
        logic [31:0] pat;
        logic [3:0]  byp_tdi;
        logic [3:0]  byp_exp;
        pat     = 32'hA5A5_A5A5;
        byp_tdi = 4'b1101;   // applied LSB first: 1,0,1,1
`ifdef SCR1_TAPC_BYPASS_EN
        byp_exp = 4'b1010;   // expected LSB first: 0,1,0,1
`else
        byp_exp = 4'b0000;
`endif
        rst_n = 1'b0; tms = 1'b1; tdi = 1'b0; dr_tdo = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ir_value", 32'(ir_value), 32'h01);
        check("rst_rst_n_sync", 32'(rst_n_sync), 0);
        check("rst_select", 32'(fsm_dr_select), 32'b0001);
        check("rst_tdo_en", 32'(tdo_en), 0);
        check("rst_dr_ctrl", {29'b0, fsm_dr_capture, fsm_dr_shift, fsm_dr_update}, 0);
        rst_n = 1'b1;
        step(1);
        check("tlr_hold_sync", 32'(rst_n_sync), 0);
        step(0);
        check("rti_rst_n_sync", 32'(rst_n_sync), 1);

        // IDCODE DR scan, DR0 drives the pattern; other DRs drive 1 to expose mux leaks
        cnt_en = 1'b1;
        dr_tdo = 4'b1110;
        step(1); step(0); step(0);
        for (int k = 0; k < 32; k++) begin
            dr_tdo[0] = pat[k];
            exp_q.push_back(pat[k]);
            step(k == 31);
        end
        step(1); step(0);
        cnt_en = 1'b0;
        check("dr_capture_cycles", 32'(cap_cnt), 1);
        check("dr_shift_cycles", 32'(shf_cnt), 32);
        check("dr_update_cycles", 32'(upd_cnt), 1);

        ir_scan(5'h03, 1'b0);
        check("ir03_value", 32'(ir_value), 32'h03);
        check("ir03_select", 32'(fsm_dr_select), 32'b0100);

        // Reset in the middle of a DR scan on DR2
        dr_tdo = 4'b0100;
        step(1); step(0); step(0);
        exp_q.push_back(1'b1);
        step(0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ir_value", 32'(ir_value), 32'h01);
        check("midrst_rst_n_sync", 32'(rst_n_sync), 0);
        check("midrst_shift", 32'(fsm_dr_shift), 0);
        check("midrst_select", 32'(fsm_dr_select), 32'b0001);
        @(negedge clk); #1;
        check("midrst_tdo_en", 32'(tdo_en), 0);
        rst_n = 1'b1;
        step(0);

        // BYPASS instruction, every external DR drives 1
        ir_scan(5'h1F, 1'b0);
        check("byp_ir_value", 32'(ir_value), 32'h1F);
        check("byp_select", 32'(fsm_dr_select), 0);
        dr_tdo = 4'b1111;
        step(1); step(0); step(0);
        for (int k = 0; k < 4; k++) begin
            tdi = byp_tdi[k];
            exp_q.push_back(byp_exp[k]);
            step(k == 3);
        end
        tdi = 1'b0;
        step(1); step(0);

        // Five TMS=1 clocks from RTI land in Test-Logic-Reset
        step(1); step(1);
        check("tlr_path_sync", 32'(rst_n_sync), 1);
        step(1); step(1); step(1);
        check("tlr5_rst_n_sync", 32'(rst_n_sync), 0);
        check("tlr5_ir_value", 32'(ir_value), 32'h01);
        step(0);

        ir_scan(5'h02, 1'b1);
        check("pause_ir_value", 32'(ir_value), 32'h02);
        check("pause_select", 32'(fsm_dr_select), 32'b0010);

        repeat (3) step(0);
        check("tdo_queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
